// File: rtl/alu_pkg.sv
// Shared op codes, FSM state encoding and the status-flag bundle for alu_seq.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_NOT  = 4'd2;
    localparam logic [3:0] OP_SHL  = 4'd3;
    localparam logic [3:0] OP_SHR  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_SLTU = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [3:0] OP_DIVU = 4'd9;
    localparam logic [3:0] OP_REMU = 4'd10;
    localparam logic [3:0] OP_SRA  = 4'd11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef struct packed {
        logic zero;
        logic neg;
        logic carry;
        logic ovf;
        logic dz;
        logic illegal;
    } alu_flags_t;

    function automatic alu_flags_t pack_flags(input logic zero, input logic neg,
                                              input logic carry, input logic ovf,
                                              input logic dz, input logic illegal);
        alu_flags_t f;
        f.zero    = zero;
        f.neg     = neg;
        f.carry   = carry;
        f.ovf     = ovf;
        f.dz      = dz;
        f.illegal = illegal;
        return f;
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier and restoring divider, one bit per cycle.
// The divider is only built when ALU_SEQ_DIV_EN is defined.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef ALU_SEQ_DIV_EN
    input  logic             div_sel,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] prod
);

    localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH - 1);
    localparam logic [SHW:0] CNT_ONE  = {{SHW{1'b0}}, 1'b1};

    // x_r: multiplicand (MUL) or dividend/quotient shifter (DIV); y_r: multiplier or divisor
    logic [SHW:0]   cnt_r;
    logic           busy_r;
    logic [WIDTH-1:0] x_r;
    logic [WIDTH-1:0] y_r;
    logic [WIDTH:0]   acc_r;
    logic [WIDTH-1:0] x_n_s;
    logic [WIDTH-1:0] y_n_s;
    logic [WIDTH:0]   acc_n_s;
`ifdef ALU_SEQ_DIV_EN
    logic             div_r;
    logic [WIDTH:0]   rem_sh_s;
    logic [WIDTH:0]   diff_s;
`endif

    // Next value of the datapath for one iteration step
    always_comb begin
        x_n_s   = x_r << 1;
        y_n_s   = y_r >> 1;
        acc_n_s = y_r[0] ? (acc_r + {1'b0, x_r}) : acc_r;
`ifdef ALU_SEQ_DIV_EN
        rem_sh_s = {acc_r[WIDTH-1:0], x_r[WIDTH-1]};
        diff_s   = rem_sh_s - {1'b0, y_r};
        if (div_r) begin
            y_n_s = y_r;
            if (!diff_s[WIDTH]) begin
                acc_n_s = diff_s;
                x_n_s   = {x_r[WIDTH-2:0], 1'b1};
            end else begin
                acc_n_s = rem_sh_s;
                x_n_s   = {x_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            y_n_s = y_r >> 1;
        end
`endif
    end

    // The last step's outputs are taken combinationally so the top can register them on the same edge
    assign done = busy_r && (cnt_r == CNT_LAST);
    assign prod = acc_n_s[WIDTH-1:0];
`ifdef ALU_SEQ_DIV_EN
    assign quo  = x_n_s;
    assign rem  = acc_n_s[WIDTH-1:0];
`endif

    // Iteration registers and counter
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r  <= {(SHW+1){1'b0}};
            busy_r <= 1'b0;
            x_r    <= {WIDTH{1'b0}};
            y_r    <= {WIDTH{1'b0}};
            acc_r  <= {(WIDTH+1){1'b0}};
`ifdef ALU_SEQ_DIV_EN
            div_r  <= 1'b0;
`endif
        end else if (start) begin
            cnt_r  <= {(SHW+1){1'b0}};
            busy_r <= 1'b1;
            x_r    <= a;
            y_r    <= b;
            acc_r  <= {(WIDTH+1){1'b0}};
`ifdef ALU_SEQ_DIV_EN
            div_r  <= div_sel;
`endif
        end else if (busy_r) begin
            cnt_r  <= cnt_r + CNT_ONE;
            busy_r <= !done;
            x_r    <= x_n_s;
            y_r    <= y_n_s;
            acc_r  <= acc_n_s;
        end else begin
            busy_r <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle ops plus iterative MUL/DIVU/REMU.
// Define ALU_SEQ_DIV_EN to build the divider; otherwise ops 9/10 are illegal.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             neg,
    output logic             carry,
    output logic             ovf,
    output logic             dz,
    output logic             illegal
);

    localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);
    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

    logic [1:0]       state_r;
    logic [WIDTH-1:0] result_r;
    alu_flags_t       flags_r;
    logic             out_valid_r;

    logic [WIDTH-1:0] res_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   dif_s;
    logic             big_s;
    logic             carry_s;
    logic             ovf_s;
    logic             dz_s;
    logic             illegal_s;
    logic             start_s;
    logic             iter_done_s;
    logic [WIDTH-1:0] prod_s;
`ifdef ALU_SEQ_DIV_EN
    logic             div_op_s;
    logic             rem_sel_r;
    logic [WIDTH-1:0] quo_s;
    logic [WIDTH-1:0] rem_s;
`endif

    // Single-cycle results and flags straight from the request operands
    always_comb begin
        res_s     = ZERO_W;
        carry_s   = 1'b0;
        ovf_s     = 1'b0;
        dz_s      = 1'b0;
        illegal_s = 1'b0;
        sum_s     = {1'b0, a} + {1'b0, b};
        dif_s     = {1'b0, a} - {1'b0, b};
        big_s     = (b >= W_VAL);
        case (op)
            OP_ADD: begin
                res_s   = sum_s[WIDTH-1:0];
                carry_s = sum_s[WIDTH];
                ovf_s   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res_s   = dif_s[WIDTH-1:0];
                carry_s = dif_s[WIDTH];
                ovf_s   = (a[WIDTH-1] != b[WIDTH-1]) && (dif_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_NOT:  res_s = ~a;
            OP_SHL:  res_s = big_s ? ZERO_W : (a << b[SHW-1:0]);
            OP_SHR:  res_s = big_s ? ZERO_W : (a >> b[SHW-1:0]);
            OP_AND:  res_s = a & b;
            OP_OR:   res_s = a | b;
            OP_SLTU: res_s = {{(WIDTH-1){1'b0}}, dif_s[WIDTH]};
            OP_MUL:  res_s = ZERO_W;
            OP_SRA:  res_s = big_s ? {WIDTH{a[WIDTH-1]}} : $unsigned($signed(a) >>> b[SHW-1:0]);
`ifdef ALU_SEQ_DIV_EN
            // Only reaches the output when b == 0; nonzero divisors go through the iterator
            OP_DIVU: begin
                res_s = {WIDTH{1'b1}};
                dz_s  = 1'b1;
            end
            OP_REMU: begin
                res_s = a;
                dz_s  = 1'b1;
            end
`endif
            default: illegal_s = 1'b1;
        endcase
    end

    // Launch the iterator for MUL, and for DIVU/REMU with a nonzero divisor
    always_comb begin
`ifdef ALU_SEQ_DIV_EN
        div_op_s = ((op == OP_DIVU) || (op == OP_REMU)) && (b != ZERO_W);
        start_s  = (state_r == ST_IDLE) && in_valid && ((op == OP_MUL) || div_op_s);
`else
        start_s  = (state_r == ST_IDLE) && in_valid && (op == OP_MUL);
`endif
    end

    alu_muldiv_iter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_iter (
        .clk     (clk),
        .rst     (rst),
        .start   (start_s),
`ifdef ALU_SEQ_DIV_EN
        .div_sel (div_op_s),
        .quo     (quo_s),
        .rem     (rem_s),
`endif
        .a       (a),
        .b       (b),
        .done    (iter_done_s),
        .prod    (prod_s)
    );

    // Control FSM and registered result/flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            result_r    <= ZERO_W;
            flags_r     <= pack_flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            out_valid_r <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            rem_sel_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (op == OP_MUL) begin
                            state_r <= ST_MUL;
`ifdef ALU_SEQ_DIV_EN
                        end else if (div_op_s) begin
                            state_r   <= ST_DIV;
                            rem_sel_r <= (op == OP_REMU);
`endif
                        end else begin
                            state_r     <= ST_DONE;
                            result_r    <= res_s;
                            flags_r     <= pack_flags(res_s == ZERO_W, res_s[WIDTH-1],
                                                      carry_s, ovf_s, dz_s, illegal_s);
                            out_valid_r <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_MUL: begin
                    if (iter_done_s) begin
                        state_r     <= ST_DONE;
                        result_r    <= prod_s;
                        flags_r     <= pack_flags(prod_s == ZERO_W, prod_s[WIDTH-1],
                                                  1'b0, 1'b0, 1'b0, 1'b0);
                        out_valid_r <= 1'b1;
                    end else begin
                        state_r <= ST_MUL;
                    end
                end
`ifdef ALU_SEQ_DIV_EN
                ST_DIV: begin
                    if (iter_done_s) begin
                        state_r     <= ST_DONE;
                        result_r    <= rem_sel_r ? rem_s : quo_s;
                        flags_r     <= pack_flags((rem_sel_r ? rem_s : quo_s) == ZERO_W,
                                                  rem_sel_r ? rem_s[WIDTH-1] : quo_s[WIDTH-1],
                                                  1'b0, 1'b0, 1'b0, 1'b0);
                        out_valid_r <= 1'b1;
                    end else begin
                        state_r <= ST_DIV;
                    end
                end
`endif
                ST_DONE: begin
                    if (out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_r == ST_IDLE);
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign zero      = flags_r.zero;
    assign neg       = flags_r.neg;
    assign carry     = flags_r.carry;
    assign ovf       = flags_r.ovf;
    assign dz        = flags_r.dz;
    assign illegal   = flags_r.illegal;

endmodule
